// File: rtl/pipe_cu_if.sv
// Control-unit bus for pipe_cu: ID instruction and EX flags in, pipeline control and stage strobes out.
interface pipe_cu_if #(parameter int RF_AW = 5);
  logic [31:0]      id_ir;
  logic             id_valid;
  logic             cf, zf, vf, sf;
  logic             stall, flush;
  logic [1:0]       pc_sel;
  logic [3:0]       ex_alufn;
  logic             ex_alusrc;
  logic [1:0]       ex_regwritesrc;
  logic [1:0]       fwd_a, fwd_b;
  logic             mem_read, mem_write;
  logic [1:0]       mem_sizesel;
  logic             mem_unsigned;
  logic             wb_regwrite, wb_memtoreg;
  logic [RF_AW-1:0] wb_rd;

  modport master (
    output id_ir, id_valid, cf, zf, vf, sf,
    input  stall, flush, pc_sel, ex_alufn, ex_alusrc, ex_regwritesrc, fwd_a, fwd_b,
           mem_read, mem_write, mem_sizesel, mem_unsigned, wb_regwrite, wb_memtoreg, wb_rd
  );
  modport slave (
    input  id_ir, id_valid, cf, zf, vf, sf,
    output stall, flush, pc_sel, ex_alufn, ex_alusrc, ex_regwritesrc, fwd_a, fwd_b,
           mem_read, mem_write, mem_sizesel, mem_unsigned, wb_regwrite, wb_memtoreg, wb_rd
  );
endinterface

// File: rtl/pipe_cu.sv
// Pipelined RV32I control unit: decode, ID/EX-EX/MEM-MEM/WB control bundles, branch resolve, hazards.
// Optional feature macro: FORWARDING_EN (operand forwarding; without it, stall on any RAW in EX/MEM).
module pipe_cu #(
  parameter int RF_AW            = 5,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input logic     clk,
  input logic     rst,
  pipe_cu_if.slave bus
);
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_PASS = 4'b0011,
                         ALU_OR  = 4'b0100, ALU_AND = 4'b0101, ALU_XOR  = 4'b0111,
                         ALU_SRL = 4'b1000, ALU_SLL = 4'b1001, ALU_SRA  = 4'b1010,
                         ALU_SLT = 4'b1101, ALU_SLTU = 4'b1111;

  if (LOAD_USE_BUBBLES != 1 && LOAD_USE_BUBBLES != 2) begin : g_bad_lub
    $error("LOAD_USE_BUBBLES must be 1 or 2");
  end

  typedef struct packed {
    logic             valid;
    logic [RF_AW-1:0] rd, rs1, rs2;
    logic [2:0]       funct3;
    logic             is_branch, is_jal, is_jalr, is_load;
    logic [3:0]       alufn;
    logic             alusrc;
    logic [1:0]       rws;
    logic             memread, memwrite;
    logic [1:0]       sizesel;
    logic             uns;
    logic             regwrite, memtoreg;
  } ctl_t;

  ctl_t idex_q, exmem_q, memwb_q;
  ctl_t dec, bub, idex_d;
  logic use1, use2, taken, redir_br, redir_jr, raw;

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // rs fields of unused operands are zeroed so they never match a writer.
  function automatic logic hit(input ctl_t b, input ctl_t d);
    return b.valid && b.regwrite && d.valid && (d.rs1 == b.rd || d.rs2 == b.rd);
  endfunction

  always_comb begin
    logic [2:0] f3;
    f3   = bus.id_ir[14:12];
    bub  = '0;
    bub.alufn = ALU_PASS;
    dec  = bub;
    use1 = 1'b0;
    use2 = 1'b0;
    if (bus.id_valid) begin
      case (bus.id_ir[6:0])
        7'b0110011: begin dec.valid = 1'b1; use1 = 1'b1; use2 = 1'b1; dec.regwrite = 1'b1;
                          dec.rws = 2'b10; dec.alufn = alu_of(f3, bus.id_ir[30]); end
        7'b0010011: begin dec.valid = 1'b1; use1 = 1'b1; dec.alusrc = 1'b1; dec.regwrite = 1'b1;
                          dec.rws = 2'b10; dec.alufn = alu_of(f3, f3 == 3'b101 && bus.id_ir[30]); end
        7'b0000011: begin dec.valid = 1'b1; use1 = 1'b1; dec.alusrc = 1'b1; dec.alufn = ALU_ADD;
                          dec.memread = 1'b1; dec.memtoreg = 1'b1; dec.regwrite = 1'b1;
                          dec.rws = 2'b10; dec.is_load = 1'b1; dec.uns = f3[2]; end
        7'b0100011: begin dec.valid = 1'b1; use1 = 1'b1; use2 = 1'b1; dec.alusrc = 1'b1;
                          dec.alufn = ALU_ADD; dec.memwrite = 1'b1; end
        7'b1100011: begin dec.valid = 1'b1; use1 = 1'b1; use2 = 1'b1; dec.alufn = ALU_SUB;
                          dec.is_branch = 1'b1; end
        7'b1101111: begin dec.valid = 1'b1; dec.regwrite = 1'b1; dec.rws = 2'b01; dec.is_jal = 1'b1; end
        7'b1100111: begin dec.valid = 1'b1; use1 = 1'b1; dec.alusrc = 1'b1; dec.alufn = ALU_ADD;
                          dec.regwrite = 1'b1; dec.rws = 2'b01; dec.is_jalr = 1'b1; end
        7'b0110111: begin dec.valid = 1'b1; dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.rws = 2'b10; end
        7'b0010111: begin dec.valid = 1'b1; dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.rws = 2'b00; end
        default: ;
      endcase
    end
    if (dec.valid) begin
      dec.rd      = bus.id_ir[7 +: RF_AW];
      dec.rs1     = use1 ? bus.id_ir[15 +: RF_AW] : '0;
      dec.rs2     = use2 ? bus.id_ir[20 +: RF_AW] : '0;
      dec.funct3  = f3;
      dec.sizesel = (dec.memread || dec.memwrite) ?
                    ((f3[1:0] == 2'b00) ? 2'b01 : (f3[1:0] == 2'b01) ? 2'b10 : 2'b00) : 2'b00;
      if (dec.rd == '0) dec.regwrite = 1'b0;
    end
  end

  always_comb begin
    case (idex_q.funct3)
      3'b000:  taken = bus.zf;
      3'b001:  taken = !bus.zf;
      3'b100:  taken = bus.sf != bus.vf;
      3'b101:  taken = bus.sf == bus.vf;
      3'b110:  taken = !bus.cf;
      3'b111:  taken = bus.cf;
      default: taken = 1'b0;
    endcase
    redir_br = idex_q.valid && (idex_q.is_jal || (idex_q.is_branch && taken));
    redir_jr = idex_q.valid && idex_q.is_jalr;
  end

`ifdef FORWARDING_EN
  function automatic logic [1:0] fwd(input logic [RF_AW-1:0] rs);
    if (exmem_q.regwrite && !exmem_q.is_load && exmem_q.rd == rs) return 2'b10;
    if (memwb_q.regwrite && memwb_q.rd == rs)                      return 2'b01;
    return 2'b00;
  endfunction

  assign raw = (hit(idex_q, dec) && idex_q.is_load) ||
               (LOAD_USE_BUBBLES == 2 && hit(exmem_q, dec) && exmem_q.is_load);
  assign bus.fwd_a = fwd(idex_q.rs1);
  assign bus.fwd_b = fwd(idex_q.rs2);
`else
  // Write-first register file: a writer already in WB is never a hazard.
  assign raw = hit(idex_q, dec) || hit(exmem_q, dec);
  assign bus.fwd_a = 2'b00;
  assign bus.fwd_b = 2'b00;
`endif

  assign bus.flush  = redir_br || redir_jr;
  assign bus.stall  = raw && !bus.flush;
  assign bus.pc_sel = redir_jr ? 2'b10 : redir_br ? 2'b01 : 2'b00;
  assign idex_d     = (bus.flush || raw) ? bub : dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= idex_q;
      memwb_q <= exmem_q;
    end
  end

  assign bus.ex_alufn       = idex_q.alufn;
  assign bus.ex_alusrc      = idex_q.alusrc;
  assign bus.ex_regwritesrc = idex_q.rws;
  assign bus.mem_read       = exmem_q.memread;
  assign bus.mem_write      = exmem_q.memwrite;
  assign bus.mem_sizesel    = exmem_q.sizesel;
  assign bus.mem_unsigned   = exmem_q.uns;
  assign bus.wb_regwrite    = memwb_q.regwrite;
  assign bus.wb_memtoreg    = memwb_q.memtoreg;
  assign bus.wb_rd          = memwb_q.rd;

  logic unused_bits;
  assign unused_bits = ^{bus.id_ir, exmem_q, memwb_q, idex_q};
endmodule

// File: doc/pipe_cu.md
Name: pipe_cu

Overview:
- Pipelined control unit for the 5-stage RV32I machine (IF/ID/EX/MEM/WB).
- Decodes the ID-stage instruction into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers.
- Resolves branches and jumps in EX from the ALU flags.
- Generates load-use stall, flush, PC-select and operand-forwarding selects.
- Replaces the single-cycle CU; datapath pipeline registers stay outside this block.

Parameters:
- RF_AW, 5: register address width. 5 = RV32I; 4 = RV32E, where rs/rd upper bits are ignored.
- LOAD_USE_BUBBLES, 1: bubbles inserted on a load-use hazard. Legal values 1 or 2; use 2 when data memory returns in WB.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset; reset is synchronous and active-high
- id_ir  in  32  instruction in ID
- id_valid  in  1  ID instruction is real (0 = bubble)
- cf, zf, vf, sf  in  1 each  ALU flags of the EX-stage instruction (subtract result)
- stall  out  1  hold PC and IF/ID
- flush  out  1  squash IF/ID
- pc_sel  out  2  00 = pc+4, 01 = branch/JAL target, 10 = JALR target
- ex_alufn  out  4  ALU function (defines.v codes)
- ex_alusrc  out  1  1 = immediate operand
- ex_regwritesrc  out  2  00 = AUIPC sum, 01 = pc+4, 10 = ALU/mem
- fwd_a, fwd_b  out  2  00 = regfile, 10 = EX/MEM result, 01 = MEM/WB result
- mem_read, mem_write  out  1 each  data memory strobes
- mem_sizesel  out  2  00 = word, 01 = byte, 10 = half
- mem_unsigned  out  1  zero-extend load
- wb_regwrite  out  1  write enable
- wb_memtoreg  out  1  write-back source select
- wb_rd  out  RF_AW  destination register

Behaviour:
- Decode (combinational from id_ir):
  - alufn, alusrc, memread/memwrite, memtoreg, regwrite, regwritesrc per opcode, same encodings as the single-cycle CU. Load/store sizes per funct3.
  - mem_unsigned = 1 for LBU/LHU.
  - Unknown opcode or id_valid=0 gives the NOP bundle (all strobes 0, alufn = ALU_PASS).
- Register-use rules:
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used by R-type, branch and store.
  - rd=0 never creates a hazard, never forwards, and forces regwrite=0.
- Pipeline registers: ID/EX, EX/MEM and MEM/WB bundles each carry valid, rd, rs1, rs2, funct3, the is_branch/is_jal/is_jalr/is_load flags and the stage strobes. They advance every cycle.
- EX resolution (combinational from ID/EX and the flags):
  - BEQ zf; BNE !zf; BLT sf!=vf; BGE sf==vf; BLTU !cf; BGEU cf.
  - JAL and a taken branch drive pc_sel=01. JALR drives pc_sel=10.
  - Any redirect asserts flush=1 for that cycle.
  - On flush, ID/EX loads a bubble on the next edge. Redirect penalty is 2 instructions.
- Load-use stall:
  - stall=1 when the ID/EX bundle is a valid load with rd matching a used rs of the ID instruction.
  - If LOAD_USE_BUBBLES=2, the same check also applies to EX/MEM.
  - On stall: ID/EX loads a bubble; EX/MEM and MEM/WB advance.
- Priority: flush wins over stall. When both conditions hold, stall=0 and flush=1.
- Forwarding (FORWARDING_EN defined), for each EX operand:
  - 10 when EX/MEM regwrite && !is_load && rd==rs.
  - Else 01 when MEM/WB regwrite && rd==rs.
  - Else 00. EX/MEM has priority over MEM/WB.
- Output timing:
  - stall, flush, pc_sel and fwd_* are combinational from registered state plus id_ir/flags.
  - ex_*/mem_*/wb_* come straight from the ID/EX, EX/MEM and MEM/WB registers.
- Reset:
  - On a rst edge all three bundles become bubbles (valid=0). This applies mid-operation too.
  - Following that edge: every output is 0, pc_sel=00, fwd_*=00, wb_rd=0.

Optional Feature:
- FORWARDING_EN defined: forwarding as above; stall only on load-use.
- Undefined:
  - fwd_a and fwd_b are tied to 00.
  - stall=1 whenever a used rs of the ID instruction matches the rd of a valid regwrite bundle in ID/EX or EX/MEM.
  - The register file is write-first, so a WB-stage writer is not a hazard.

Test Plan:
- Back-to-back dependent ADDs: "add x1,x2,x3; add x4,x1,x1".
  - FORWARDING_EN defined: second in EX has fwd_a=fwd_b=10; stall never 1.
  - Undefined: stall=1 for 2 cycles.
- Load-use: "lw x5,0(x1); addi x6,x5,1".
  - stall=1 for exactly LOAD_USE_BUBBLES cycles.
  - The ADDI then sees fwd_a=01 (LOAD_USE_BUBBLES=1).
- BEQ taken in EX:
  - Flags zf=1 gives pc_sel=01 and flush=1 for 1 cycle; next ex_* = NOP.
  - BGE with sf=1, vf=1 gives taken; BLTU with cf=1 gives not taken (pc_sel=00).
- JALR x1 in EX with a load-use hazard in ID in the same cycle: pc_sel=10, flush=1, stall=0.
- Writes to x0: "addi x0,x0,5; add x7,x0,x0" gives wb_regwrite=0, fwd_a=fwd_b=00, stall=0.
- Reset mid-stream: rst=1 for 1 cycle while a store is in EX.
  - Next cycle mem_write=0, wb_regwrite=0, pc_sel=00.
  - Outputs remain 0 until new instructions propagate.
